// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings, tag indices, FSM states and trigger decode for the UART receive path
package uart_pkg;

  // word_len encoding
  localparam logic [1:0] WL_5 = 2'b00;
  localparam logic [1:0] WL_6 = 2'b01;
  localparam logic [1:0] WL_7 = 2'b10;
  localparam logic [1:0] WL_8 = 2'b11;

  // error tag bit indices within the 3-bit tag field
  localparam int ERR_BRK = 2;
  localparam int ERR_FE  = 1;
  localparam int ERR_PE  = 0;

  localparam int DATA_W  = 8;
  localparam int ERR_W   = 3;
  localparam int ENTRY_W = DATA_W + ERR_W;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_e;

  // Occupancy at which trig_hit asserts for a FIFO of the given depth.
  function automatic int unsigned trig_decode(input logic [1:0] lvl, input int unsigned depth);
    case (lvl)
      2'b00:   return 32'd1;
      2'b01:   return depth >> 2;
      2'b10:   return depth >> 1;
      default: return depth - 32'd2;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO with tag tracking and single-entry mode
module uart_rx_fifo #(
  parameter int DEPTH   = 16,
  parameter int WIDTH   = 11,
  parameter int TAG_LSB = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     single,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     err_any,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    err_cnt_q;

  logic [CW-1:0] cap;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          push_tag;
  logic          head_tag;

  // In single-entry mode the same storage is used but capacity drops to one.
  assign cap      = single ? CW'(1) : CW'(DEPTH);
  assign full     = (count_q >= cap);
  assign empty    = (count_q == '0);
  assign do_pop   = pop && !empty && !clr;
  assign do_push  = push && !clr && (!full || do_pop);
  assign overflow = push && !clr && full && !do_pop;
  assign push_tag = |push_data[WIDTH-1:TAG_LSB];
  assign head_tag = |mem_q[rd_q][WIDTH-1:TAG_LSB];

  assign head    = empty ? '0 : mem_q[rd_q];
  assign count   = count_q;
  assign err_any = (err_cnt_q != '0);

  // Pointer, occupancy and tagged-entry bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q   <= count_q + CW'(do_push) - CW'(do_pop);
      err_cnt_q <= err_cnt_q + CW'(do_push && push_tag) - CW'(do_pop && head_tag);
    end
  end

  // Entry storage; contents are only visible while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - oversampling UART receiver with FIFO, trigger level and character timeout
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          RXD,
  input  logic [DIV_W-1:0]              divisor,
  input  logic [1:0]                    word_len,
  input  logic                          parity_en,
  input  logic                          even_par,
  input  logic                          stick_par,
  input  logic                          fifo_en,
  input  logic [1:0]                    trig_lvl,
  input  logic                          rx_pop,
  input  logic                          fifo_clr,
  input  logic                          ovr_clr,
  output logic [7:0]                    rx_data,
  output logic [2:0]                    rx_err,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          fifo_err,
  output logic                          trig_hit,
  output logic                          timeout
);

  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int TO_LIMIT = 40 * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic fall;

  logic [DIV_W-1:0] div_cnt_q;
  logic             div_nz;
  logic             tick;

  rx_state_e       state_q, state_d;
  logic [SW-1:0]   samp_q, samp_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            pbit_q, pbit_d;
  logic            perr_q, perr_d;
  logic            push_q, push_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [ERR_W-1:0]   err_tag;

  logic [2:0] last_bit;
  logic       par_exp;
  logic       samp_mid;
  logic       samp_end;

  logic [ENTRY_W-1:0] head;
  logic               empty;
  logic               overflow;
  logic               err_any;
  logic               overrun_q;
  logic [TO_W-1:0]    to_q;
  logic [CNT_W-1:0]   trig_level;

  assign fall     = rxd_prev_q && !rxd_s2_q;
  assign div_nz   = (divisor != '0);
  assign tick     = div_nz && (div_cnt_q == '0);
  assign last_bit = {1'b0, word_len} + 3'd4;
  assign par_exp  = stick_par ? ~even_par : (even_par ? ^data_q : ~(^data_q));
  assign samp_mid = tick && (samp_q == SW'(OVERSAMPLE / 2 - 1));
  assign samp_end = tick && (samp_q == SW'(OVERSAMPLE - 1));

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= RXD;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  // Sample-tick divider: reload divisor-1 on each tick, idle at zero when divisor is 0.
  always_ff @(posedge PCLK) begin
    if (PRESET || !div_nz) begin
      div_cnt_q <= '0;
    end else if (div_cnt_q == '0) begin
      div_cnt_q <= divisor - DIV_W'(1);
    end else begin
      div_cnt_q <= div_cnt_q - DIV_W'(1);
    end
  end

  // Receiver FSM and frame datapath registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      pbit_q  <= 1'b0;
      perr_q  <= 1'b0;
      push_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      pbit_q  <= pbit_d;
      perr_q  <= perr_d;
      push_q  <= push_d;
      entry_q <= entry_d;
    end
  end

  // Next-state: start validation at half a bit, then one sample per bit centre.
  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pbit_d  = pbit_q;
    perr_d  = perr_q;
    push_d  = 1'b0;
    entry_d = entry_q;
    err_tag = '0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d = ST_START;
          samp_d  = '0;
        end
      end
      ST_START: begin
        if (samp_mid) begin
          samp_d = '0;
          if (rxd_s2_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            bit_d   = '0;
            data_d  = '0;
            pbit_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end else if (tick) begin
          samp_d = samp_q + SW'(1);
        end
      end
      ST_DATA: begin
        if (samp_end) begin
          samp_d         = '0;
          data_d[bit_q]  = rxd_s2_q;
          if (bit_q == last_bit) begin
            state_d = parity_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else if (tick) begin
          samp_d = samp_q + SW'(1);
        end
      end
      ST_PARITY: begin
        if (samp_end) begin
          samp_d  = '0;
          pbit_d  = rxd_s2_q;
          perr_d  = (rxd_s2_q != par_exp);
          state_d = ST_STOP;
        end else if (tick) begin
          samp_d = samp_q + SW'(1);
        end
      end
      ST_STOP: begin
        if (samp_end) begin
          samp_d = '0;
          push_d = 1'b1;
          if (!rxd_s2_q && (data_q == '0) && !pbit_q) begin
            err_tag[ERR_BRK] = 1'b1;
            err_tag[ERR_FE]  = 1'b1;
            entry_d = {err_tag, 8'h00};
            state_d = ST_BREAK_WAIT;
          end else begin
            err_tag[ERR_FE] = ~rxd_s2_q;
            err_tag[ERR_PE] = perr_q;
            entry_d = {err_tag, data_q};
            state_d = ST_IDLE;
          end
        end else if (tick) begin
          samp_d = samp_q + SW'(1);
        end
      end
      ST_BREAK_WAIT: begin
        if (rxd_s2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!div_nz) begin
      state_d = ST_IDLE;
      push_d  = 1'b0;
    end
  end

  uart_rx_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .WIDTH   (ENTRY_W),
    .TAG_LSB (DATA_W)
  ) u_fifo (
    .clk       (PCLK),
    .rst       (PRESET),
    .clr       (fifo_clr),
    .single    (~fifo_en),
    .push      (push_q),
    .push_data (entry_q),
    .pop       (rx_pop),
    .head      (head),
    .count     (rx_count),
    .empty     (empty),
    .err_any   (err_any),
    .overflow  (overflow)
  );

  // Sticky overrun: a dropped push wins over a same-cycle clear.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      overrun_q <= 1'b0;
    end else if (overflow) begin
      overrun_q <= 1'b1;
    end else if (ovr_clr) begin
      overrun_q <= 1'b0;
    end
  end

  // Character timeout: count ticks while data waits, restart on any FIFO activity.
  always_ff @(posedge PCLK) begin
    if (PRESET || fifo_clr || push_q || rx_pop || empty) begin
      to_q <= '0;
    end else if (tick && (to_q != TO_W'(TO_LIMIT))) begin
      to_q <= to_q + TO_W'(1);
    end
  end

  assign trig_level = fifo_en ? CNT_W'(trig_decode(trig_lvl, FIFO_DEPTH)) : CNT_W'(1);

  assign rx_data  = head[DATA_W-1:0];
  assign rx_err   = head[ENTRY_W-1:DATA_W];
  assign rx_valid = !empty;
  assign overrun  = overrun_q;
  assign fifo_err = err_any;
  assign trig_hit = (rx_count >= trig_level);
  assign timeout  = fifo_en && (to_q == TO_W'(TO_LIMIT));

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - directed self-checking bench for uart_rx_engine
module tb_uart_rx_engine;

  localparam int BIT = 32;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        RXD;
  logic [15:0] divisor;
  logic [1:0]  word_len;
  logic        parity_en, even_par, stick_par, fifo_en;
  logic [1:0]  trig_lvl;
  logic        rx_pop, fifo_clr, ovr_clr;
  logic [7:0]  rx_data;
  logic [2:0]  rx_err;
  logic        rx_valid;
  logic [4:0]  rx_count;
  logic        overrun, fifo_err, trig_hit, timeout;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_engine #(.FIFO_DEPTH(16), .OVERSAMPLE(16), .DIV_W(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .RXD(RXD), .divisor(divisor),
    .word_len(word_len), .parity_en(parity_en), .even_par(even_par),
    .stick_par(stick_par), .fifo_en(fifo_en), .trig_lvl(trig_lvl),
    .rx_pop(rx_pop), .fifo_clr(fifo_clr), .ovr_clr(ovr_clr),
    .rx_data(rx_data), .rx_err(rx_err), .rx_valid(rx_valid),
    .rx_count(rx_count), .overrun(overrun), .fifo_err(fifo_err),
    .trig_hit(trig_hit), .timeout(timeout)
  );

  always #5 PCLK = ~PCLK;

  task automatic cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic use_par,
                            input logic pbit, input logic stop_bit);
    RXD = 1'b0;
    cyc(BIT);
    for (int i = 0; i < nbits; i++) begin
      RXD = d[i];
      cyc(BIT);
    end
    if (use_par) begin
      RXD = pbit;
      cyc(BIT);
    end
    RXD = stop_bit;
    cyc(BIT);
    RXD = 1'b1;
  endtask

  task automatic pulse_pop();
    rx_pop = 1'b1;
    cyc(1);
    rx_pop = 1'b0;
    cyc(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rx_data"},  32'(rx_data),  32'h0);
    check({tag, ".rx_err"},   32'(rx_err),   32'h0);
    check({tag, ".rx_valid"}, 32'(rx_valid), 32'h0);
    check({tag, ".rx_count"}, 32'(rx_count), 32'h0);
    check({tag, ".overrun"},  32'(overrun),  32'h0);
    check({tag, ".fifo_err"}, 32'(fifo_err), 32'h0);
    check({tag, ".trig_hit"}, 32'(trig_hit), 32'h0);
    check({tag, ".timeout"},  32'(timeout),  32'h0);
  endtask

  initial begin
    logic [7:0] ch;
    int k;
    PRESET = 1'b1; RXD = 1'b1; divisor = 16'd2;
    word_len = 2'b11; parity_en = 1'b1; even_par = 1'b0; stick_par = 1'b0;
    fifo_en = 1'b1; trig_lvl = 2'b00;
    rx_pop = 1'b0; fifo_clr = 1'b0; ovr_clr = 1'b0;
    cyc(4);
    PRESET = 1'b0;
    cyc(1);
    check_reset_outputs("reset");
    cyc(BIT);

    // 8O1, 0xA7 has five ones so the odd parity bit is 0
    send_frame(8'hA7, 8, 1'b1, 1'b0, 1'b1);
    cyc(4);
    check("a7.rx_valid", 32'(rx_valid), 32'h1);
    check("a7.rx_count", 32'(rx_count), 32'h1);
    check("a7.rx_data",  32'(rx_data),  32'hA7);
    check("a7.rx_err",   32'(rx_err),   32'h0);
    check("a7.fifo_err", 32'(fifo_err), 32'h0);
    check("a7.trig_hit", 32'(trig_hit), 32'h1);
    pulse_pop();
    check("a7.pop.rx_valid", 32'(rx_valid), 32'h0);

    // same character with wrong parity bit
    send_frame(8'hA7, 8, 1'b1, 1'b1, 1'b1);
    cyc(4);
    check("pe.rx_data",  32'(rx_data),  32'hA7);
    check("pe.rx_err",   32'(rx_err),   32'h1);
    check("pe.fifo_err", 32'(fifo_err), 32'h1);
    pulse_pop();
    check("pe.pop.rx_valid", 32'(rx_valid), 32'h0);
    check("pe.pop.fifo_err", 32'(fifo_err), 32'h0);

    // break: 11 bit times low, then idle
    RXD = 1'b0;
    cyc(11 * BIT);
    RXD = 1'b1;
    cyc(2 * BIT);
    check("brk.rx_count", 32'(rx_count), 32'h1);
    check("brk.rx_data",  32'(rx_data),  32'h0);
    check("brk.rx_err",   32'(rx_err),   32'h6);
    check("brk.fifo_err", 32'(fifo_err), 32'h1);
    pulse_pop();
    check("brk.pop.rx_count", 32'(rx_count), 32'h0);

    // 17 characters without popping: 16 stored, 17th dropped
    for (int i = 1; i <= 17; i++) begin
      ch = 8'(8'h10 + i);
      send_frame(ch, 8, 1'b1, ~(^ch), 1'b1);
      cyc(BIT / 2);
    end
    check("ovr.rx_count", 32'(rx_count), 32'd16);
    check("ovr.overrun",  32'(overrun),  32'h1);
    check("ovr.rx_data",  32'(rx_data),  32'h11);
    check("ovr.rx_err",   32'(rx_err),   32'h0);
    fifo_clr = 1'b1;
    cyc(1);
    fifo_clr = 1'b0;
    cyc(1);
    check("clr.rx_count", 32'(rx_count), 32'h0);
    check("clr.overrun",  32'(overrun),  32'h1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    cyc(1);
    check("ovrclr.overrun", 32'(overrun), 32'h0);

    // 5N1 with trigger at DEPTH/4 = 4
    word_len = 2'b00; parity_en = 1'b0; trig_lvl = 2'b01;
    cyc(BIT);
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1);
      cyc(4);
    end
    check("trig3.trig_hit", 32'(trig_hit), 32'h0);
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1);
    cyc(2);
    check("trig4.trig_hit", 32'(trig_hit), 32'h1);
    check("trig4.rx_count", 32'(rx_count), 32'd4);
    check("trig4.rx_data",  32'(rx_data),  32'h15);
    cyc(1200);
    check("to.early", 32'(timeout), 32'h0);
    k = 0;
    while (!timeout && k < 300) begin
      cyc(1);
      k++;
    end
    check("to.hit", 32'(timeout), 32'h1);
    pulse_pop();
    check("to.pop.timeout",  32'(timeout),  32'h0);
    check("to.pop.rx_count", 32'(rx_count), 32'd3);
    fifo_clr = 1'b1;
    cyc(1);
    fifo_clr = 1'b0;
    cyc(1);

    // false start: 4 ticks low
    RXD = 1'b0;
    cyc(8);
    RXD = 1'b1;
    cyc(3 * BIT);
    check("fs.rx_valid", 32'(rx_valid), 32'h0);
    check("fs.rx_count", 32'(rx_count), 32'h0);

    // reset in the middle of a data field
    send_frame(8'h15, 5, 1'b0, 1'b0, 1'b1);
    cyc(4);
    check("pre.rx_count", 32'(rx_count), 32'h1);
    RXD = 1'b0; cyc(BIT);
    RXD = 1'b1; cyc(BIT);
    RXD = 1'b0; cyc(BIT);
    PRESET = 1'b1;
    RXD = 1'b1;
    cyc(2);
    check_reset_outputs("midrst");
    PRESET = 1'b0;
    cyc(BIT);
    send_frame(8'h0A, 5, 1'b0, 1'b0, 1'b1);
    cyc(4);
    check("post.rx_count", 32'(rx_count), 32'h1);
    check("post.rx_data",  32'(rx_data),  32'h0A);
    check("post.rx_err",   32'(rx_err),   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_engine.md
# uart_rx_engine

Parametrised UART receive path for the uart_16550 family: an oversampling serial receiver, a FIFO of configurable depth with per-entry error tags, a trigger level and a character timeout. It sits between the RXD pin and the APB register file. The register file owns the LCR/FCR/DLL/DLM storage and drives this block's static configuration and pop/clear strobes. Frame format covers 5–8 data bits, none/odd/even/stick parity, and break detection.

## Interface
- FIFO_DEPTH, 16, entries (power of two, ≥4)
- OVERSAMPLE, 16, sample ticks per bit (even, ≥8)
- DIV_W, 16, divisor width
- PCLK  in  1  clock
- PRESET  in  1  reset, synchronous, active-high
- RXD  in  1  serial input, asynchronous
- divisor  in  DIV_W  PCLK cycles per sample tick; 0 holds receiver in IDLE
- word_len  in  2  00=5, 01=6, 10=7, 11=8 data bits
- parity_en / even_par / stick_par  in  1 each  LCR[3]/[4]/[5] semantics
- fifo_en  in  1  0 = single-entry holding register (depth 1)
- trig_lvl  in  2  00=1, 01=DEPTH/4, 10=DEPTH/2, 11=DEPTH-2
- rx_pop  in  1  one-cycle read strobe (RBR read)
- fifo_clr  in  1  flush FIFO, timeout counter
- ovr_clr  in  1  clear overrun (LSR read)
- rx_data  out  8  head data, zero-extended above word_len
- rx_err  out  3  head tags {break, framing, parity}
- rx_valid  out  1  FIFO non-empty (LSR.DR)
- rx_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- overrun  out  1  sticky
- fifo_err  out  1  any stored entry has a nonzero tag (LSR[7])
- trig_hit  out  1  rx_count ≥ trigger level
- timeout  out  1  character timeout pending

## Operation
- RXD passes through a 2-flop synchroniser; both flops reset to 1.
- Tick generator: counter loads divisor-1 and counts down; tick pulses one cycle at 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - IDLE → START: synchronised falling edge.
  - START: resample at OVERSAMPLE/2 ticks. If high → IDLE (false start). If low → DATA.
  - DATA: sample every OVERSAMPLE ticks at bit centre, LSB first, for word_len+5 bits.
  - After DATA: → PARITY if parity_en, else → STOP.
- Parity check:
  - stick_par=1: expected bit = ~even_par.
  - Otherwise: odd or even over the received data bits.
  - Mismatch sets the parity tag.
- STOP: sample one stop bit only; 0 sets the framing tag.
  - Break: data, parity and stop bits all 0. Push data 0x00 with break and framing tags, then go to BREAK_WAIT.
  - Otherwise push the character and go to IDLE.
- BREAK_WAIT: stay until RXD is synchronised high, then → IDLE. Only one entry is pushed per break.
- FIFO: first-word-fall-through; rx_data/rx_err show the head.
  - rx_pop on empty: ignored.
  - Push on full without pop: new character discarded, overrun set.
  - Push and pop in the same cycle on full: both occur, no overrun.
- overrun clears on ovr_clr. If set and cleared in the same cycle, set wins.
- fifo_clr empties the FIFO and leaves overrun unchanged. Push in the same cycle as fifo_clr is dropped.
- timeout:
  - Tick counter increments while FIFO non-empty.
  - Counter resets on push, pop or fifo_clr.
  - timeout asserts at 40×OVERSAMPLE ticks (4 character times at 10 bits).
  - Forced 0 when fifo_en=0.

## Timing
- Reset values: rx_data 0, rx_err 0, rx_valid 0, rx_count 0, overrun 0, fifo_err 0, trig_hit 0, timeout 0. FSM in IDLE, tick counter 0.
- Synchroniser latency: 2 cycles.
- Push happens in the cycle after the stop-bit sample tick. rx_valid/rx_count update one cycle after the push.
- Pop: head advances and rx_count decrements in the cycle after rx_pop.
- Configuration changes take effect at the next start bit. Changes mid-frame are undefined.
- PRESET mid-frame aborts the frame with no push; RXD must idle high before the next start is accepted.

## Structure
- Shared package uart_pkg:
  - word_len encoding
  - error tag bit indices (ERR_BRK=2, ERR_FE=1, ERR_PE=0)
  - FSM state enum
  - trigger-level decode function
- Sub-module uart_rx_fifo: synchronous FWFT FIFO, 11-bit entries, count output, clear input.
- FSM, tick generator, parity logic and timeout counter live in uart_rx_engine.

## Test plan
- divisor=2, OVERSAMPLE=16 (32 cycles/bit), 8O1, send 0xA7 with parity 0 → one push, rx_data=0xA7, rx_err=0, rx_valid=1.
- Same frame with parity bit 1 → rx_err=3'b001, fifo_err=1; rx_pop → rx_valid=0, fifo_err=0.
- Pull RXD low for 11 bit times, then high → exactly one entry, 0x00, rx_err=3'b110.
- fifo_en=1, FIFO_DEPTH=16, send 17 chars with no pops → rx_count=16, overrun=1, head still char 1; ovr_clr → overrun=0.
- 5N1, send 0x15, trig_lvl=01 after 4 chars → trig_hit=1; stop sending → timeout=1 after 640 ticks; rx_pop → timeout=0.
- 0-pulse on RXD of 4 ticks (false start) → no push. PRESET mid-DATA → all outputs at reset values, next clean frame received correctly.
